// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between the receive-echo path and keypad reporting.
// Echo bytes sit in a small FIFO, key presses in a one-entry register; frames are paced by an internal timer.
module uart_tx_arbiter #(
  parameter int unsigned CLK_FREQ   = 24_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FRAME_BITS = 10,
  parameter int unsigned GAP_CLKS   = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic [3:0] key_value,
  input  logic       key_valid,
  input  logic       ovf_clr,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       busy,
  output logic       rx_ovf,
  output logic       key_ovf
);

  localparam int unsigned FRAME_CLKS = (CLK_FREQ / BAUD) * FRAME_BITS + GAP_CLKS;
  localparam int unsigned CNT_W      = (FRAME_CLKS > 2) ? $clog2(FRAME_CLKS) : 1;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(FRAME_CLKS - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;
  typedef enum logic {SRC_RX, SRC_KEY} src_t;

  state_t           state_q, state_d;
  src_t             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic             rx_ovf_q, rx_ovf_d;
  logic             key_ovf_q, key_ovf_d;

  logic [7:0]       fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             key_full_q, key_full_d;
  logic [3:0]       key_code_q, key_code_d;

  logic fifo_empty, fifo_full;
  logic rx_pop, rx_push, rx_drop;
  logic key_pop, key_load, key_drop;
  logic grant_rx;
  logic [7:0] key_ascii;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FIFO_FULL);

  // A pop in the same cycle frees the slot, so a push/load into a full buffer is only lost without one.
  assign rx_push  = rx_valid & (~fifo_full | rx_pop);
  assign rx_drop  = rx_valid & fifo_full & ~rx_pop;
  assign key_load = key_valid & (~key_full_q | key_pop);
  assign key_drop = key_valid & key_full_q & ~key_pop;

  assign key_ascii = (key_code_q < 4'd10) ? ({4'h0, key_code_q} + 8'h30)
                                          : ({4'h0, key_code_q} + 8'h37);

  assign grant_rx = ~fifo_empty & (~key_full_q | (last_q == SRC_KEY));

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    rx_pop     = 1'b0;
    key_pop    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_rx) begin
          rx_pop     = 1'b1;
          tx_data_d  = fifo_mem_q[rd_ptr_q];
          tx_start_d = 1'b1;
          cnt_d      = CNT_LOAD;
          last_d     = SRC_RX;
          state_d    = ST_WAIT;
        end else if (key_full_q) begin
          key_pop    = 1'b1;
          tx_data_d  = key_ascii;
          tx_start_d = 1'b1;
          cnt_d      = CNT_LOAD;
          last_d     = SRC_KEY;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (rx_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rx_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({rx_push, rx_pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    key_full_d = key_full_q;
    key_code_d = key_code_q;
    if (key_load) begin
      key_full_d = 1'b1;
      key_code_d = key_value;
    end else if (key_pop) begin
      key_full_d = 1'b0;
    end
  end

  // A fresh overflow in the same cycle as a clear leaves the flag set.
  always_comb begin
    rx_ovf_d  = (rx_ovf_q & ~ovf_clr) | rx_drop;
    key_ovf_d = (key_ovf_q & ~ovf_clr) | key_drop;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      last_q     <= SRC_KEY;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      rx_ovf_q   <= 1'b0;
      key_ovf_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      key_full_q <= 1'b0;
      key_code_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      rx_ovf_q   <= rx_ovf_d;
      key_ovf_q  <= key_ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      key_full_q <= key_full_d;
      key_code_q <= key_code_d;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else if (rx_push) begin
      fifo_mem_q[wr_ptr_q] <= rx_data;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = (state_q == ST_WAIT);
  assign rx_ovf   = rx_ovf_q;
  assign key_ovf  = key_ovf_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: scoreboarded frames, ASCII table, and multi-cycle corner cases.
module tb_uart_tx_arbiter;

  localparam int FRAME_CLKS = 100;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [3:0] key_value = '0;
  logic       key_valid = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       rx_ovf;
  logic       key_ovf;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rem      = 0;
  logic [7:0] held = '0;
  logic [7:0] exp_q [$];

  typedef struct {
    logic [3:0] key;
    logic [7:0] ascii;
  } key_vec_t;
  key_vec_t kv [16];

  uart_tx_arbiter #(
    .CLK_FREQ  (100),
    .BAUD      (10),
    .FRAME_BITS(10),
    .GAP_CLKS  (0),
    .FIFO_DEPTH(4)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .key_value(key_value),
    .key_valid(key_valid),
    .ovf_clr  (ovf_clr),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .busy     (busy),
    .rx_ovf   (rx_ovf),
    .key_ovf  (key_ovf)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame monitor: every tx_start consumes one scoreboard entry; busy must span exactly FRAME_CLKS cycles.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      rem = 0;
    end else begin
      if (tx_start) begin
        chk("start_while_busy", rem, 0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_start: got tx_data 0x%0h expected no tx_start (cycle %0d)", tx_data, cyc);
        end else begin
          chk("tx_data", tx_data, exp_q.pop_front());
        end
        rem  = FRAME_CLKS;
        held = tx_data;
      end else if (rem > 0) begin
        chk("tx_data_hold", tx_data, held);
      end
      chk("busy", busy, (rem > 0) ? 1 : 0);
      if (rem > 0) rem--;
    end
  end

  task automatic strobe(input logic rv, input logic [7:0] rd, input logic kv_en, input logic [3:0] kval,
                        output int c);
    @(posedge sys_clk); #1;
    rx_valid  = rv;
    rx_data   = rd;
    key_valid = kv_en;
    key_value = kval;
    c = cyc;
    @(posedge sys_clk); #1;
    rx_valid  = 1'b0;
    key_valid = 1'b0;
  endtask

  task automatic wait_start(output int c);
    bit found = 0;
    c = -1;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge sys_clk);
      if (tx_start) begin
        found = 1;
        c = cyc;
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL wait_start_timeout: got no tx_start expected one within 400 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge sys_clk);
      if (exp_q.size() == 0 && !busy && !tx_start) done = 1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL wait_idle_timeout: got %0d frames pending expected 0", exp_q.size());
    end
  endtask

  task automatic wait_until(input int target);
    do begin
      @(posedge sys_clk); #1;
    end while (cyc < target);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rx_ovf"}, rx_ovf, 0);
    chk({tag, "_key_ovf"}, key_ovf, 0);
  endtask

  task automatic do_reset();
    @(posedge sys_clk); #3;
    sys_rst = 1'b1;
    exp_q.delete();
    #1;
    check_reset_outputs("rst");
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
  endtask

  initial begin
    int c0, s0, s1, s2, s3, s4;

    kv[0]  = '{4'hB, 8'h42}; kv[1]  = '{4'h7, 8'h37}; kv[2]  = '{4'h0, 8'h30}; kv[3]  = '{4'h1, 8'h31};
    kv[4]  = '{4'h2, 8'h32}; kv[5]  = '{4'h3, 8'h33}; kv[6]  = '{4'h4, 8'h34}; kv[7]  = '{4'h5, 8'h35};
    kv[8]  = '{4'h6, 8'h36}; kv[9]  = '{4'h8, 8'h38}; kv[10] = '{4'h9, 8'h39}; kv[11] = '{4'hA, 8'h41};
    kv[12] = '{4'hC, 8'h43}; kv[13] = '{4'hD, 8'h44}; kv[14] = '{4'hE, 8'h45}; kv[15] = '{4'hF, 8'h46};

    // Reset state, then idle with no strobes: the monitor flags any tx_start.
    #2;
    check_reset_outputs("init");
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    repeat (10) @(posedge sys_clk);
    #1;
    check_reset_outputs("idle");

    // Echo latency: strobe in N, tx_start in N+2.
    exp_q.push_back(8'h55);
    strobe(1'b1, 8'h55, 1'b0, 4'h0, c0);
    wait_start(s0);
    chk("echo_latency", s0 - c0, 2);
    wait_idle();

    // Key-to-ASCII table; first entries are 0xB then 0x7.
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(kv[i].ascii);
      strobe(1'b0, 8'h00, 1'b1, kv[i].key, c0);
      wait_start(s0);
      chk("key_latency", s0 - c0, 2);
      wait_idle();
    end

    // Tie after reset: echo first, then alternation under sustained ties.
    do_reset();
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h41);
    strobe(1'b1, 8'h31, 1'b1, 4'hA, c0);
    wait_start(s0);
    wait_start(s1);
    chk("rr_gap1", s1 - s0, FRAME_CLKS + 1);
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h31);
    strobe(1'b1, 8'h61, 1'b1, 4'h1, c0);
    wait_start(s2);
    chk("rr_gap2", s2 - s1, FRAME_CLKS + 1);
    exp_q.push_back(8'h62);
    strobe(1'b1, 8'h62, 1'b0, 4'h0, c0);
    wait_start(s3);
    chk("rr_gap3", s3 - s2, FRAME_CLKS + 1);
    wait_start(s4);
    chk("rr_gap4", s4 - s3, FRAME_CLKS + 1);
    wait_idle();

    // Overflow: 5 echo bytes and 2 keys during WAIT; last grant is echo so the key goes next.
    exp_q.push_back(8'hA0);
    strobe(1'b1, 8'hA0, 1'b0, 4'h0, c0);
    wait_start(s0);
    exp_q.push_back(8'h33);
    for (int b = 1; b <= 4; b++) exp_q.push_back(8'(b));
    for (int b = 1; b <= 5; b++) strobe(1'b1, 8'(b), 1'b0, 4'h0, c0);
    chk("rx_ovf_set", rx_ovf, 1);
    chk("key_ovf_before", key_ovf, 0);
    strobe(1'b0, 8'h00, 1'b1, 4'h3, c0);
    strobe(1'b0, 8'h00, 1'b1, 4'h9, c0);
    chk("key_ovf_set", key_ovf, 1);
    @(posedge sys_clk); #1;
    ovf_clr = 1'b1;
    @(posedge sys_clk); #1;
    ovf_clr = 1'b0;
    chk("rx_ovf_clr", rx_ovf, 0);
    chk("key_ovf_clr", key_ovf, 0);
    wait_start(s1);
    chk("ovf_gap", s1 - s0, FRAME_CLKS + 1);
    // Push into the full FIFO in the very cycle 0x01 is popped: accepted, no overflow.
    exp_q.push_back(8'h06);
    wait_until(s1 + FRAME_CLKS);
    rx_valid = 1'b1;
    rx_data  = 8'h06;
    @(posedge sys_clk); #1;
    rx_valid = 1'b0;
    chk("full_push_pop_ovf", rx_ovf, 0);
    wait_idle();
    chk("full_push_pop_ovf_end", rx_ovf, 0);

    // Reset mid-WAIT at counter 50 with two bytes buffered.
    exp_q.push_back(8'hC0);
    strobe(1'b1, 8'hC0, 1'b0, 4'h0, c0);
    wait_start(s0);
    strobe(1'b1, 8'hC1, 1'b0, 4'h0, c0);
    strobe(1'b1, 8'hC2, 1'b0, 4'h0, c0);
    wait_until(s0 + 49);
    chk("pre_rst_busy", busy, 1);
    #2;
    sys_rst = 1'b1;
    exp_q.delete();
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    repeat (300) @(posedge sys_clk);
    #1;
    check_reset_outputs("post_rst");

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule
